// File: rtl/wb_write_buffer_pkg.sv
// Shared datapath constants for the writeback buffer: default widths, depth
// and the hard-wired zero register index.
package wb_write_buffer_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH_DEF  = 4;
    localparam int ZERO_REG   = 0;
endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the pending writes, used to forward buffered
// data to the decode stage before it reaches the register file.
module wb_fwd_match
    import wb_write_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic [DEPTH-1:0]                    valid_i,
    input  logic [DEPTH-1:0][ADDR_W-1:0]        sel_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]        data_i,
    input  logic [$clog2(DEPTH)-1:0]            head_i,
    input  logic [ADDR_W-1:0]                   fwd_sel_i,
    output logic                                hit_o,
    output logic [DATA_W-1:0]                   data_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0]             match;
    logic [DEPTH-1:0][DATA_W-1:0] rot_data;

    // Rotate so that position 0 is the oldest entry and DEPTH-1 the youngest.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rot
            logic [PTR_W-1:0] rot_idx;
            assign rot_idx      = head_i + PTR_W'(gi);
            assign match[gi]    = valid_i[rot_idx] && (sel_i[rot_idx] == fwd_sel_i);
            assign rot_data[gi] = data_i[rot_idx];
        end
    endgenerate

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        if (fwd_sel_i != ADDR_W'(ZERO_REG)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (match[i]) begin
                    hit_o  = 1'b1;
                    data_o = rot_data[i];
                end
            end
        end
    end
endmodule

// File: rtl/wb_write_buffer.sv
// Writeback buffer: queues register-file writes in FIFO order, drains one per
// cycle when the write port is free, and forwards pending data to decode.
module wb_write_buffer
    import wb_write_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_sel,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       rf_stall,
    output logic                       rf_write_enable,
    output logic [ADDR_W-1:0]          rf_write_select,
    output logic [DATA_W-1:0]          rf_write_data,
    input  logic [ADDR_W-1:0]          fwd_sel,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] sel_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [PTR_W-1:0]             head_q, head_d;
    logic [PTR_W-1:0]             tail_q, tail_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         empty, full, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // Readiness ignores a same-cycle pop: no pass-through when full.
    assign in_ready        = !full;
    assign rf_write_enable = !empty && !rf_stall;
    assign rf_write_select = empty ? '0 : sel_q[head_q];
    assign rf_write_data   = empty ? '0 : data_q[head_q];
    assign count           = count_q;

    assign push = in_valid && in_ready && (in_sel != ADDR_W'(ZERO_REG));
    assign pop  = rf_write_enable;

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; every use is qualified by count or valid.
    always_ff @(posedge clk) begin
        if (push) begin
            sel_q[tail_q]  <= in_sel;
            data_q[tail_q] <= in_data;
        end
    end

    wb_fwd_match #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fwd_match (
        .valid_i   (valid_q),
        .sel_i     (sel_q),
        .data_i    (data_q),
        .head_i    (head_q),
        .fwd_sel_i (fwd_sel),
        .hit_o     (fwd_hit),
        .data_o    (fwd_data)
    );
endmodule

// File: tb/tb_wb_write_buffer.sv
// Self-checking bench for wb_write_buffer: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_wb_write_buffer;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] sel;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] in_sel = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              rf_stall = 1'b0;
    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_write_select;
    logic [DATA_W-1:0] rf_write_data;
    logic [ADDR_W-1:0] fwd_sel = '0;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    wr_t mq[$];    // model contents, oldest first
    wr_t mlog[$];  // writes the model says reached the register file
    wr_t dlog[$];  // writes observed on the DUT port

    always #5 clk = ~clk;

    wb_write_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_sel          (in_sel),
        .in_data         (in_data),
        .rf_stall        (rf_stall),
        .rf_write_enable (rf_write_enable),
        .rf_write_select (rf_write_select),
        .rf_write_data   (rf_write_data),
        .fwd_sel         (fwd_sel),
        .fwd_hit         (fwd_hit),
        .fwd_data        (fwd_data),
        .count           (count)
    );

    // Reference model: plain queue semantics evaluated at each rising edge.
    function automatic bit m_hit(input logic [ADDR_W-1:0] s);
        if (s == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].sel == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DATA_W-1:0] m_fdata(input logic [ADDR_W-1:0] s);
        if (s == 0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].sel == s) return mq[i].data;
        return '0;
    endfunction

    task automatic advance();
        bit m_we, m_push;
        @(negedge clk);
        if (rf_write_enable === 1'b1) begin
            dlog.push_back(wr_t'{rf_write_select, rf_write_data});
            $display("rf write sel=%0d data=%h", rf_write_select, rf_write_data);
        end
        @(posedge clk);
        if (reset) begin
            mq.delete();
        end else begin
            m_we   = (mq.size() != 0) && !rf_stall;
            m_push = in_valid && (mq.size() != DEPTH) && (in_sel != 0);
            if (m_we) begin
                mlog.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (m_push) mq.push_back(wr_t'{in_sel, in_data});
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 0; in_sel = '0; in_data = '0; rf_stall = 0; fwd_sel = '0;
        advance();
        advance();
        reset = 1'b0;
        mlog.delete();
        dlog.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 0; rf_stall = 0; fwd_sel = 5'd3;
        advance();
        #1;
        checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++; if (rf_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", rf_write_enable); end
        checks++; if (rf_write_select !== '0 || rf_write_data !== '0) begin errors++;
            $display("FAIL reset_head got=%0d/%h exp=0/0", rf_write_select, rf_write_data); end
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd got=%b exp=0", fwd_hit); end
        do_reset();
    endtask

    task automatic test_single_write();
        in_valid = 1; in_sel = 5'd10; in_data = 32'h0AB5;
        advance();
        in_valid = 0;
        #1;
        checks++; if (rf_write_enable !== 1'b1 || rf_write_select !== 5'd10 || rf_write_data !== 32'h0AB5) begin
            errors++; $display("FAIL single_write got=%b/%0d/%h exp=1/10/00000ab5",
                               rf_write_enable, rf_write_select, rf_write_data); end
        advance();
        #1;
        checks++; if (count !== 0) begin errors++; $display("FAIL single_drain got=%0d exp=0", count); end
        checks++; if (dlog.size() != 1 || mlog.size() != 1) begin errors++;
            $display("FAIL single_log got=%0d exp=1", dlog.size()); end
        do_reset();
    endtask

    task automatic test_zero_reg();
        in_valid = 1; in_sel = 5'd0; in_data = 32'hFFFF; fwd_sel = 5'd0;
        for (int c = 0; c < 3; c++) begin
            advance();
            #1;
            checks++; if (count !== 0 || rf_write_enable !== 1'b0 || fwd_hit !== 1'b0) begin errors++;
                $display("FAIL zero_reg got=cnt%0d we%b hit%b exp=cnt0 we0 hit0", count, rf_write_enable, fwd_hit); end
        end
        in_valid = 0;
        do_reset();
    endtask

    task automatic test_stall_full();
        rf_stall = 1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1; in_sel = ADDR_W'(i); in_data = 32'(i * 16 + i);
            for (int b = 0; b < 8 && !in_ready; b++) begin
                #1;
                checks++; if (count !== 4) begin errors++; $display("FAIL full_hold_cnt got=%0d exp=4", count); end
                checks++; if (rf_write_select !== 5'd1 || rf_write_data !== 32'h11) begin errors++;
                    $display("FAIL full_hold_head got=%0d/%h exp=1/11", rf_write_select, rf_write_data); end
                if (b == 2) rf_stall = 0;
                advance();
            end
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_accept_%0d got=%b exp=1", i, in_ready); end
            advance();
            if (i == 4) begin
                #1;
                checks++; if (count !== 4 || in_ready !== 1'b0) begin errors++;
                    $display("FAIL full_after4 got=cnt%0d rdy%b exp=cnt4 rdy0", count, in_ready); end
            end
        end
        in_valid = 0; rf_stall = 0;
        for (int c = 0; c < 6; c++) advance();
        checks++; if (dlog.size() != 5) begin errors++; $display("FAIL full_writes got=%0d exp=5", dlog.size()); end
        for (int i = 0; i < dlog.size() && i < 5; i++) begin
            checks++; if (dlog[i].sel !== ADDR_W'(i + 1) || dlog[i].data !== 32'((i + 1) * 17)) begin errors++;
                $display("FAIL full_order[%0d] got=%0d/%h exp=%0d/%h", i, dlog[i].sel, dlog[i].data, i + 1, (i + 1) * 17); end
        end
        do_reset();
    endtask

    task automatic test_forwarding();
        rf_stall = 1; in_valid = 1;
        in_sel = 5'd9; in_data = 32'h100; advance();
        in_sel = 5'd9; in_data = 32'h200; advance();
        in_sel = 5'd8; in_data = 32'h300; fwd_sel = 5'd8;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== '0) begin errors++;
            $display("FAIL fwd_incoming got=%b/%h exp=0/0", fwd_hit, fwd_data); end
        in_valid = 0; fwd_sel = 5'd9;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h200) begin errors++;
            $display("FAIL fwd_youngest got=%b/%h exp=1/200", fwd_hit, fwd_data); end
        fwd_sel = 5'd8;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== '0) begin errors++;
            $display("FAIL fwd_miss got=%b/%h exp=0/0", fwd_hit, fwd_data); end
        do_reset();
    endtask

    task automatic test_wrap();
        int sent = 0;
        for (int c = 0; c < 60 && (sent < 10 || mq.size() != 0); c++) begin
            rf_stall = c[0];
            in_valid = (sent < 10); in_sel = ADDR_W'(sent + 2); in_data = 32'hA000 + 32'(sent);
            #1;
            if (in_valid && in_ready) sent++;
            advance();
            checks++; if (count > DEPTH || count !== mq.size()) begin errors++;
                $display("FAIL wrap_count got=%0d exp=%0d", count, mq.size()); end
        end
        in_valid = 0; rf_stall = 0;
        checks++; if (dlog.size() != 10) begin errors++; $display("FAIL wrap_writes got=%0d exp=10", dlog.size()); end
        for (int i = 0; i < dlog.size() && i < 10; i++) begin
            checks++; if (dlog[i].sel !== ADDR_W'(i + 2) || dlog[i].data !== 32'hA000 + 32'(i)) begin errors++;
                $display("FAIL wrap_order[%0d] got=%0d/%h exp=%0d/%h", i, dlog[i].sel, dlog[i].data, i + 2, 32'hA000 + i); end
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] e_sel;
        logic [DATA_W-1:0] e_data;
        for (int c = 0; c < 400; c++) begin
            in_valid = $urandom_range(0, 1);
            in_sel   = ($urandom_range(0, 5) == 0) ? '0 : ADDR_W'($urandom_range(1, 7));
            in_data  = $urandom;
            rf_stall = ($urandom_range(0, 2) == 0);
            fwd_sel  = ADDR_W'($urandom_range(0, 7));
            #1;
            e_sel  = (mq.size() != 0) ? mq[0].sel  : '0;
            e_data = (mq.size() != 0) ? mq[0].data : '0;
            checks++; if (count !== mq.size()) begin errors++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, mq.size()); end
            checks++; if (in_ready !== (mq.size() != DEPTH)) begin errors++; $display("FAIL rnd_ready c=%0d got=%b", c, in_ready); end
            checks++; if (rf_write_enable !== ((mq.size() != 0) && !rf_stall)) begin errors++;
                $display("FAIL rnd_we c=%0d got=%b", c, rf_write_enable); end
            checks++; if (rf_write_select !== e_sel || rf_write_data !== e_data) begin errors++;
                $display("FAIL rnd_head c=%0d got=%0d/%h exp=%0d/%h", c, rf_write_select, rf_write_data, e_sel, e_data); end
            checks++; if (fwd_hit !== m_hit(fwd_sel) || fwd_data !== m_fdata(fwd_sel)) begin errors++;
                $display("FAIL rnd_fwd c=%0d sel=%0d got=%b/%h exp=%b/%h", c, fwd_sel, fwd_hit, fwd_data,
                         m_hit(fwd_sel), m_fdata(fwd_sel)); end
            advance();
        end
        in_valid = 0;
        checks++; if (dlog.size() != mlog.size()) begin errors++;
            $display("FAIL rnd_log_len got=%0d exp=%0d", dlog.size(), mlog.size()); end
        for (int i = 0; i < dlog.size() && i < mlog.size(); i++) begin
            if (dlog[i].sel !== mlog[i].sel || dlog[i].data !== mlog[i].data) begin
                checks++; errors++;
                $display("FAIL rnd_log[%0d] got=%0d/%h exp=%0d/%h", i, dlog[i].sel, dlog[i].data, mlog[i].sel, mlog[i].data);
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        rf_stall = 1; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_sel = ADDR_W'(20 + i); in_data = 32'hC0 + 32'(i);
            advance();
        end
        in_valid = 0; rf_stall = 0;
        #1;
        checks++; if (count !== 3 || rf_write_enable !== 1'b1) begin errors++;
            $display("FAIL mid_pending got=cnt%0d we%b exp=cnt3 we1", count, rf_write_enable); end
        reset = 1'b1;
        #1;
        checks++; if (count !== 0 || rf_write_enable !== 1'b0) begin errors++;
            $display("FAIL mid_async got=cnt%0d we%b exp=cnt0 we0", count, rf_write_enable); end
        for (int c = 0; c < 3; c++) advance();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) advance();
        checks++; if (dlog.size() != 0 || count !== 0) begin errors++;
            $display("FAIL mid_no_write got=writes%0d cnt%0d exp=writes0 cnt0", dlog.size(), count); end
        do_reset();
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single_write();
        test_zero_reg();
        test_stall_full();
        test_forwarding();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
